n64_deblur_est: RTL

N64_DEBLUR_EST -- requirements
Module: n64_deblur_est

---
 rtl/n64_deblur_est_pkg.sv | 36 +++
 rtl/n64_gradient_cmp.sv | 52 +++++
 rtl/n64_deblur_est.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/n64_deblur_est_pkg.sv
// n64_deblur_est_pkg
// Shared definitions for the N64 de-blur estimator:
//   - default widths, thresholds and hit criterion
//   - output mode encodings (auto / force deblur / force no deblur / auto-frozen)
//   - pixel phase encodings of data_cnt
//   - positions of nVSYNC / nHSYNC inside the 4-bit sync nibble
package n64_deblur_est_pkg;

    localparam int COLOR_W_DEF   = 7;
    localparam int TREND_W_DEF   = 9;
    localparam int HITS_W_DEF    = 2;
    localparam int HOLDOFF_W_DEF = 2;
    localparam int CHG_MIN_DEF   = 3;

    // Hysteresis window sits symmetrically around the trend mid-point.
    localparam int TH_MARGIN_DEF = 8;

    // Bit positions inside the sync nibble (and inside D_i during nDSYNC low).
    localparam int SYNC_NVSYNC_BIT = 3;
    localparam int SYNC_NHSYNC_BIT = 1;

    typedef enum logic [1:0] {
        MODE_AUTO         = 2'b00,
        MODE_FORCE_DEBLUR = 2'b01,
        MODE_FORCE_SHARP  = 2'b10,
        MODE_AUTO_FROZEN  = 2'b11
    } deblur_mode_e;

    typedef enum logic [1:0] {
        PH_SYNC = 2'b00,
        PH_R    = 2'b01,
        PH_G    = 2'b10,
        PH_B    = 2'b11
    } pix_phase_e;

endpackage

// File: rtl/n64_gradient_cmp.sv
// n64_gradient_cmp
// One colour channel of the de-blur estimator. Computes the gradient
// {pre<cur, pre>cur} on the compared bit slice, stores it when asked, and
// flags a flip when the live gradient is the exact opposite of the stored one.
//
// Ports
//   nCLK   in   pixel clock, logic on falling edge
//   RST    in   synchronous active-high reset
//   store  in   latch the live gradient of this channel
//   pre    in   previous sample of this channel
//   cur    in   current sample of this channel
//   flip   out  stored and live gradient are opposite (rise vs. fall)
module n64_gradient_cmp #(
    parameter int COLOR_W = 7,
    parameter int CMP_MSB = 6,
    parameter int CMP_LSB = 5
) (
    input  logic               nCLK,
    input  logic               RST,
    input  logic               store,
    input  logic [COLOR_W-1:0] pre,
    input  logic [COLOR_W-1:0] cur,
    output logic               flip
);

    localparam int SLICE_W = CMP_MSB - CMP_LSB + 1;

    logic [SLICE_W-1:0] pre_s;
    logic [SLICE_W-1:0] cur_s;
    logic [1:0]         grad_new;
    logic [1:0]         grad_stored;
    logic               unused_bits;

    assign pre_s    = pre[CMP_MSB:CMP_LSB];
    assign cur_s    = cur[CMP_MSB:CMP_LSB];
    assign grad_new = {pre_s < cur_s, pre_s > cur_s};

    // Only a full reversal (10 vs 01) counts; flat on either side never flips.
    assign flip = &(grad_stored ^ grad_new);

    // Low-order bits are deliberately ignored so dither noise does not count.
    assign unused_bits = ^{pre, cur};

    always_ff @(negedge nCLK) begin
        if (RST) begin
            grad_stored <= 2'b00;
        end else if (store) begin
            grad_stored <= grad_new;
        end
    end

endmodule

// File: rtl/n64_deblur_est.sv
// n64_deblur_est
// Estimates whether the N64 output is running with its native blur filter
// enabled by watching for single-pixel gradient reversals at the positions
// where the VI would have blurred. Reversal hits are counted per frame with a
// hold-off window, folded into a saturating trend, and turned into a
// hysteretic decision at each frame boundary.
//
// Ports
//   nCLK              in   pixel clock, all logic on falling edge
//   RST               in   synchronous active-high reset
//   nDSYNC            in   low = sync / pixel boundary phase
//   data_cnt          in   phase within pixel (01 R, 10 G, 11 B)
//   vdata_pre         in   previous word {sync[3:0], R, G, B}
//   vdata_cur         in   current D_i; bits 3/1 carry nVSYNC/nHSYNC when nDSYNC low
//   n64_480i          in   interlaced mode, estimator idle
//   blurry_pixel_pos  in   marks a potentially blurred pixel
//   mode              in   00 auto, 01 force deblur, 10 force no deblur, 11 auto-frozen
//   ndo_deblur        out  0 = apply deblur
//   nblur_est         out  estimator decision (1 = N64 blur off)
//   trend_o           out  current trend value
//   hits_o            out  hit count latched at last frame boundary
module n64_deblur_est
    import n64_deblur_est_pkg::*;
#(
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int CMP_MSB   = COLOR_W - 1,
    parameter int CMP_LSB   = COLOR_W - 2,
    parameter int TREND_W   = TREND_W_DEF,
    parameter int HITS_W    = HITS_W_DEF,
    parameter int HOLDOFF_W = HOLDOFF_W_DEF,
    parameter int TH_HI     = 2**(TREND_W-1) + TH_MARGIN_DEF,
    parameter int TH_LO     = 2**(TREND_W-1) - TH_MARGIN_DEF,
    parameter int CHG_MIN   = CHG_MIN_DEF
) (
    input  logic                   nCLK,
    input  logic                   RST,
    input  logic                   nDSYNC,
    input  logic [1:0]             data_cnt,
    input  logic [3*COLOR_W+3:0]   vdata_pre,
    input  logic [COLOR_W-1:0]     vdata_cur,
    input  logic                   n64_480i,
    input  logic                   blurry_pixel_pos,
    input  logic [1:0]             mode,
    output logic                   ndo_deblur,
    output logic                   nblur_est,
    output logic [TREND_W-1:0]     trend_o,
    output logic [HITS_W-1:0]      hits_o
);

    localparam int SYNC_LSB = 3*COLOR_W;

    localparam logic [TREND_W-1:0]   TREND_RST = TREND_W'(2**(TREND_W-1));
    localparam logic [TREND_W-1:0]   TH_HI_V   = TREND_W'(TH_HI);
    localparam logic [TREND_W-1:0]   TH_LO_V   = TREND_W'(TH_LO);
    localparam logic [1:0]           CHG_MIN_V = 2'(CHG_MIN);
    localparam logic [HOLDOFF_W-1:0] HOLD_ONE  = HOLDOFF_W'(1);

    deblur_mode_e mode_e;
    pix_phase_e   phase;

    logic [COLOR_W-1:0] pre_r;
    logic [COLOR_W-1:0] pre_g;
    logic [COLOR_W-1:0] pre_b;

    logic est_en;
    logic grad_phase;
    logic cmp_phase;
    logic eval_phase;
    logic store_r;
    logic store_g;
    logic store_b;
    logic flip_r;
    logic flip_g;
    logic flip_b;
    logic neg_v;
    logic neg_h;
    logic hit;
    logic unused_sync;

    // Estimator state
    logic [1:0]           chg_cnt;
    logic [HITS_W-1:0]    hits;
    logic [HOLDOFF_W-1:0] holdoff;
    logic [TREND_W-1:0]   trend;
    logic                 run_est;

    logic [1:0]           chg_cnt_nxt;
    logic [HITS_W-1:0]    hits_nxt;
    logic [HOLDOFF_W-1:0] holdoff_nxt;
    logic [TREND_W-1:0]   trend_nxt;
    logic                 run_nxt;
    logic                 nblur_nxt;
    logic                 ndo_nxt;
    logic [HITS_W-1:0]    hits_o_nxt;

    assign mode_e = deblur_mode_e'(mode);
    assign phase  = pix_phase_e'(data_cnt);

    assign pre_r = vdata_pre[3*COLOR_W-1 -: COLOR_W];
    assign pre_g = vdata_pre[2*COLOR_W-1 -: COLOR_W];
    assign pre_b = vdata_pre[COLOR_W-1:0];

    // Sync nibble bits 2 and 0 carry nothing the estimator needs.
    assign unused_sync = ^{vdata_pre[SYNC_LSB+2], vdata_pre[SYNC_LSB]};

    assign est_en     = ~n64_480i;
    assign grad_phase = nDSYNC & est_en;
    assign cmp_phase  = grad_phase & ~blurry_pixel_pos;
    assign eval_phase = ~nDSYNC & est_en & ~blurry_pixel_pos;

    assign store_r = grad_phase & blurry_pixel_pos & (phase == PH_R);
    assign store_g = grad_phase & blurry_pixel_pos & (phase == PH_G);
    assign store_b = grad_phase & blurry_pixel_pos & (phase == PH_B);

    assign neg_v = ~nDSYNC & vdata_pre[SYNC_LSB+SYNC_NVSYNC_BIT] & ~vdata_cur[SYNC_NVSYNC_BIT];
    assign neg_h = ~nDSYNC & vdata_pre[SYNC_LSB+SYNC_NHSYNC_BIT] & ~vdata_cur[SYNC_NHSYNC_BIT];

    assign hit = (chg_cnt >= CHG_MIN_V);

    n64_gradient_cmp #(
        .COLOR_W (COLOR_W),
        .CMP_MSB (CMP_MSB),
        .CMP_LSB (CMP_LSB)
    ) u_grad_r (
        .nCLK  (nCLK),
        .RST   (RST),
        .store (store_r),
        .pre   (pre_r),
        .cur   (vdata_cur),
        .flip  (flip_r)
    );

    n64_gradient_cmp #(
        .COLOR_W (COLOR_W),
        .CMP_MSB (CMP_MSB),
        .CMP_LSB (CMP_LSB)
    ) u_grad_g (
        .nCLK  (nCLK),
        .RST   (RST),
        .store (store_g),
        .pre   (pre_g),
        .cur   (vdata_cur),
        .flip  (flip_g)
    );

    n64_gradient_cmp #(
        .COLOR_W (COLOR_W),
        .CMP_MSB (CMP_MSB),
        .CMP_LSB (CMP_LSB)
    ) u_grad_b (
        .nCLK  (nCLK),
        .RST   (RST),
        .store (store_b),
        .pre   (pre_b),
        .cur   (vdata_cur),
        .flip  (flip_b)
    );

    always_comb begin
        chg_cnt_nxt = chg_cnt;
        hits_nxt    = hits;
        holdoff_nxt = holdoff;
        trend_nxt   = trend;
        run_nxt     = run_est;
        nblur_nxt   = nblur_est;
        ndo_nxt     = ndo_deblur;
        hits_o_nxt  = hits_o;

        if (est_en) begin
            // R restarts the per-pixel flip count so a stale count never leaks.
            if (cmp_phase) begin
                case (phase)
                    PH_R:    chg_cnt_nxt = {1'b0, flip_r};
                    PH_G:    chg_cnt_nxt = chg_cnt + {1'b0, flip_g};
                    PH_B:    chg_cnt_nxt = chg_cnt + {1'b0, flip_b};
                    default: chg_cnt_nxt = chg_cnt;
                endcase
            end

            // A hit is only accepted outside the hold-off window; an accepted
            // hit opens a new window that runs until the counter wraps.
            if (eval_phase) begin
                if (|holdoff) begin
                    holdoff_nxt = holdoff + 1'b1;
                end else if (hit) begin
                    holdoff_nxt = HOLD_ONE;
                    if (~&hits) begin
                        hits_nxt = hits + 1'b1;
                    end
                end
                chg_cnt_nxt = 2'b00;
            end

            if (neg_h) begin
                holdoff_nxt = '0;
            end

            if (neg_v) begin
                if (run_est && (mode_e != MODE_AUTO_FROZEN)) begin
                    if (&hits) begin
                        if (~&trend) trend_nxt = trend + 1'b1;
                    end else begin
                        if (|trend) trend_nxt = trend - 1'b1;
                    end
                end
                if (trend >= TH_HI_V) begin
                    nblur_nxt = 1'b1;
                end else if (trend <= TH_LO_V) begin
                    nblur_nxt = 1'b0;
                end
                hits_o_nxt = hits;
                hits_nxt   = '0;
                run_nxt    = 1'b1;
            end
        end else begin
            // Interlaced: hold everything and make the first progressive
            // frame after it a warm-up frame.
            run_nxt = 1'b0;
        end

        // Output decision uses the pre-update estimate: one frame of lag.
        if (neg_v) begin
            if (n64_480i) begin
                ndo_nxt = 1'b1;
            end else begin
                case (mode_e)
                    MODE_FORCE_DEBLUR: ndo_nxt = 1'b0;
                    MODE_FORCE_SHARP:  ndo_nxt = 1'b1;
                    default:           ndo_nxt = nblur_est;
                endcase
            end
        end
    end

    always_ff @(negedge nCLK) begin
        if (RST) begin
            chg_cnt    <= 2'b00;
            hits       <= '0;
            holdoff    <= '0;
            trend      <= TREND_RST;
            run_est    <= 1'b0;
            nblur_est  <= 1'b1;
            ndo_deblur <= 1'b1;
            hits_o     <= '0;
        end else begin
            chg_cnt    <= chg_cnt_nxt;
            hits       <= hits_nxt;
            holdoff    <= holdoff_nxt;
            trend      <= trend_nxt;
            run_est    <= run_nxt;
            nblur_est  <= nblur_nxt;
            ndo_deblur <= ndo_nxt;
            hits_o     <= hits_o_nxt;
        end
    end

    assign trend_o = trend;

endmodule
